nonce_dispatch: RTL

- Multi-lane nonce index dispatcher that replaces the single-stream index generator.
- On start, it issues batches of LANES consecutive nonce indices to LANES parallel SHA cores.
- It records every issued batch in an in-flight FIFO, matches in-order results back to their batch, and reports the first winning index.
- It also reports range exhaustion when no index succeeds. It sits between the top-level control and the SHA core array.

---
 rtl/nonce_dispatch.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/nonce_dispatch.sv
// -----------------------------------------------------------------------------
// nonce_dispatch
//
// Multi-lane nonce index dispatcher. After a start it offers batches of LANES
// consecutive nonce indices to an array of LANES SHA cores, records every
// accepted batch in an in-flight FIFO, matches the in-order batch results back
// to their batch and reports the first winning index. If the index range runs
// out without a hit, it reports exhaustion (success=0, index=0).
//
// Handshakes:
//   issue : a batch moves to the cores on a rising clk edge where
//           issue_valid=1 and stall=0. issue_index/issue_mask are stable while
//           issue_valid=1 and stall=1, and never change without a transfer.
//   result: res_valid is a single-beat strobe with no back-pressure; every
//           cycle with res_valid=1 carries the result for the oldest batch
//           still in flight.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-low
//   start        begin a search (honoured only while idle)
//   start_index  first index of the search, sampled with start
//   stall        cores not ready; blocks the issue transfer
//   issue_valid  batch offered to the cores
//   issue_index  lane i at [i*WIDTH +: WIDTH] = base + i
//   issue_mask   lane i carries a real index (base + i did not wrap)
//   res_valid    one in-order batch result present
//   res_success  per-lane hit flags for that batch
//   busy         search in progress (RUN or DRAIN)
//   valid        one-cycle completion pulse
//   success      qualifies valid: 1 = winning index found
//   index        winning index, 0 when success=0
//   err          sticky protocol error (result with nothing in flight)
//   dbg_state    current FSM state (0=IDLE, 1=RUN, 2=DRAIN)
// -----------------------------------------------------------------------------
module nonce_dispatch #(
  parameter int WIDTH = 32,
  parameter int LANES = 4,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH-1:0]       start_index,
  input  logic                   stall,
  output logic                   issue_valid,
  output logic [LANES*WIDTH-1:0] issue_index,
  output logic [LANES-1:0]       issue_mask,
  input  logic                   res_valid,
  input  logic [LANES-1:0]       res_success,
  output logic                   busy,
  output logic                   valid,
  output logic                   success,
  output logic [WIDTH-1:0]       index,
  output logic                   err,
  output logic [1:0]             dbg_state
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int KW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [WIDTH-1:0] r_base;
  logic             r_found;

  logic [WIDTH-1:0] r_fifo_base [DEPTH];
  logic [LANES-1:0] r_fifo_mask [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;

  logic             r_valid;
  logic             r_success;
  logic [WIDTH-1:0] r_index;
  logic             r_err;

  // ---------------------------------------------------------------------------
  // Wires
  // ---------------------------------------------------------------------------
  state_t             w_state_nxt;
  logic               w_full;
  logic               w_empty;
  logic               w_issue_ok;
  logic               w_push;
  logic               w_pop;
  logic               w_res_err;
  logic [PW:0]        w_count_nxt;
  logic [WIDTH:0]     w_next_base;
  logic               w_last_batch;
  logic [WIDTH:0]     w_lane_sum [LANES];
  logic [LANES*WIDTH-1:0] w_lane_index;
  logic [LANES-1:0]   w_lane_mask;
  logic [WIDTH-1:0]   w_head_base;
  logic [LANES-1:0]   w_head_mask;
  logic [LANES-1:0]   w_hit;
  logic [KW-1:0]      w_k;
  logic               w_report_hit;
  logic               w_exhaust;

  // ---------------------------------------------------------------------------
  // Lane indices and masks. Sums are taken one bit wider than WIDTH so the
  // carry tells us whether a lane ran past the top of the index space.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_lane_sum[g]                   = {1'b0, r_base} + (WIDTH+1)'(g);
    assign w_lane_index[g*WIDTH +: WIDTH]  = w_lane_sum[g][WIDTH-1:0];
    assign w_lane_mask[g]                  = ~w_lane_sum[g][WIDTH];
  end

  // A carry out of base+LANES means this is the final batch of the range.
  assign w_next_base  = {1'b0, r_base} + (WIDTH+1)'(LANES);
  assign w_last_batch = w_next_base[WIDTH];

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping. full is judged on the current occupancy, so a pop in
  // the same cycle never frees room for a push.
  // ---------------------------------------------------------------------------
  assign w_full      = (r_count == (PW+1)'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_issue_ok  = (r_state == S_RUN) && !w_full;
  assign w_push      = w_issue_ok && !stall;
  assign w_pop       = res_valid && !w_empty && (r_state != S_IDLE);
  assign w_res_err   = res_valid && (w_empty || (r_state == S_IDLE));
  assign w_count_nxt = r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);

  assign w_head_base = r_fifo_base[r_rd_ptr];
  assign w_head_mask = r_fifo_mask[r_rd_ptr];

  // Hits on wrapped lanes are not real indices and are dropped here.
  assign w_hit = res_success & w_head_mask;

  // Lowest hitting lane wins.
  always_comb begin
    w_k = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (w_hit[i]) w_k = KW'(i);
    end
  end

  assign w_report_hit = w_pop && (w_hit != '0) && !r_found;

  // The range ran out with nothing found: the FIFO empties while draining.
  assign w_exhaust = (r_state == S_DRAIN) && (w_count_nxt == '0) &&
                     !r_found && !w_report_hit;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // A hit or the final batch both end issuing; remaining batches drain.
        if (w_report_hit || (w_push && w_last_batch)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_count_nxt == '0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    issue_valid = w_issue_ok;
    issue_index = w_issue_ok ? w_lane_index : '0;
    issue_mask  = w_issue_ok ? w_lane_mask  : '0;
    busy        = (r_state != S_IDLE);
    dbg_state   = r_state;
  end

  // ---------------------------------------------------------------------------
  // In-flight FIFO storage (contents need no reset; pointers and count do)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_base[r_wr_ptr] <= r_base;
      r_fifo_mask[r_wr_ptr] <= w_lane_mask;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: base, FIFO pointers, report and error registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_base    <= '0;
      r_found   <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_valid   <= 1'b0;
      r_success <= 1'b0;
      r_index   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_count <= w_count_nxt;

      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);

      // A new search clears the previous report; success/index hold until then.
      if ((r_state == S_IDLE) && start) begin
        r_base    <= start_index;
        r_found   <= 1'b0;
        r_success <= 1'b0;
        r_index   <= '0;
      end else if (w_push && !w_last_batch) begin
        r_base <= w_next_base[WIDTH-1:0];
      end

      if (w_report_hit) begin
        r_valid   <= 1'b1;
        r_success <= 1'b1;
        r_index   <= w_head_base + WIDTH'(w_k);
        r_found   <= 1'b1;
      end else if (w_exhaust) begin
        r_valid   <= 1'b1;
        r_success <= 1'b0;
        r_index   <= '0;
      end

      if (w_res_err) r_err <= 1'b1;
    end
  end

  assign valid   = r_valid;
  assign success = r_success;
  assign index   = r_index;
  assign err     = r_err;

endmodule
